// File: rtl/icache_nway_pkg.sv
// +--------------------------------------------------------------------------+
// | icache_nway_pkg : shared configuration for the N-way instruction cache   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

package icache_nway_pkg;

  localparam int RV_ICACHE_WAYS     = 2;
  localparam int RV_ICACHE_ELEMENTS = 64;
  localparam int RV_ICACHE_BLOCKS   = 4;

  localparam int WORD_BITS  = $clog2(RV_ICACHE_BLOCKS);
  localparam int INDEX_BITS = $clog2(RV_ICACHE_ELEMENTS);
  localparam int TAG_BITS   = 32 - 2 - WORD_BITS - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    COMMIT = 2'd2,
    FLUSH  = 2'd3
  } icache_state_t;

  typedef logic [TAG_BITS-1:0]   tag_t;
  typedef logic [INDEX_BITS-1:0] index_t;

endpackage

`default_nettype wire

// File: rtl/icache_way.sv
// +--------------------------------------------------------------------------+
// | icache_way : one way of the cache - valid/tag/data storage, tag compare  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module icache_way
  import icache_nway_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_W      = TAG_BITS,
  parameter int ELEMENTS   = RV_ICACHE_ELEMENTS,
  parameter int BLOCKS     = RV_ICACHE_BLOCKS
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [$clog2(ELEMENTS)-1:0] i_index,
  input  logic [$clog2(BLOCKS)-1:0]   i_word,
  input  logic [TAG_W-1:0]            i_tag,
  output logic                        o_match,
  output logic [DATA_WIDTH-1:0]       o_data,
  input  logic                        i_wr_en,
  input  logic [$clog2(ELEMENTS)-1:0] i_wr_index,
  input  logic [$clog2(BLOCKS)-1:0]   i_wr_word,
  input  logic [DATA_WIDTH-1:0]       i_wr_data,
  input  logic                        i_commit,
  input  logic [TAG_W-1:0]            i_commit_tag,
  input  logic                        i_flush
);

  logic [ELEMENTS-1:0]   r_valid;
  logic [TAG_W-1:0]      r_tag  [ELEMENTS];
  logic [DATA_WIDTH-1:0] r_data [ELEMENTS][BLOCKS];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_commit) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // Tag and data need no reset: nothing reads them while the valid bit is clear.
  always_ff @(posedge i_clock) begin
    if (i_commit) begin
      r_tag[i_wr_index] <= i_commit_tag;
    end
    if (i_wr_en) begin
      r_data[i_wr_index][i_wr_word] <= i_wr_data;
    end
  end

  assign o_match = r_valid[i_index] && (r_tag[i_index] == i_tag);
  assign o_data  = r_data[i_index][i_word];

endmodule

`default_nettype wire

// File: rtl/icache_nway.sv
// +--------------------------------------------------------------------------+
// | icache_nway : N-way set-associative I-cache, round-robin, flush, refill  |
// | Optional hit/miss counters when RV_ICACHE_STATS_EN is defined.           |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module icache_nway
  import icache_nway_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int WAYS       = RV_ICACHE_WAYS,
  parameter int ELEMENTS   = RV_ICACHE_ELEMENTS,
  parameter int BLOCKS     = RV_ICACHE_BLOCKS
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_rd,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_hit,
  output logic                  o_busy,
  input  logic                  i_flush,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_rd,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic                  i_mem_ack
`ifdef RV_ICACHE_STATS_EN
  ,
  output logic [31:0]           o_hit_count,
  output logic [31:0]           o_miss_count
`endif
);

  localparam int c_WB   = $clog2(BLOCKS);
  localparam int c_IB   = $clog2(ELEMENTS);
  localparam int c_TB   = ADDR_WIDTH - 2 - c_WB - c_IB;
  localparam int c_WAYB = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [ADDR_WIDTH-1:0] c_LINE_MASK = ADDR_WIDTH'(BLOCKS * 4 - 1);

  icache_state_t r_state, w_state_nx;

  logic [ADDR_WIDTH-1:0]            r_base;
  logic [c_WB-1:0]                  r_cnt;
  logic [c_WAYB-1:0]                r_victim;
  logic                             r_flush_pend;
  logic [ELEMENTS-1:0][c_WAYB-1:0]  r_rr;

  logic [WAYS-1:0]       w_match;
  logic [DATA_WIDTH-1:0] w_way_data [WAYS];
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [c_IB-1:0]       w_index, w_ref_index;
  logic [c_WB-1:0]       w_word;
  logic [c_TB-1:0]       w_tag, w_ref_tag;
  logic                  w_start_refill, w_enter_flush, w_last_ack;
  logic                  w_unused;

  assign w_word      = i_addr[2 +: c_WB];
  assign w_index     = i_addr[2 + c_WB +: c_IB];
  assign w_tag       = i_addr[ADDR_WIDTH-1 -: c_TB];
  assign w_ref_index = r_base[2 + c_WB +: c_IB];
  assign w_ref_tag   = r_base[ADDR_WIDTH-1 -: c_TB];
  assign w_unused    = &{1'b0, i_addr[1:0]};

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    icache_way #(
      .DATA_WIDTH (DATA_WIDTH),
      .TAG_W      (c_TB),
      .ELEMENTS   (ELEMENTS),
      .BLOCKS     (BLOCKS)
    ) u_way (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_index      (w_index),
      .i_word       (w_word),
      .i_tag        (w_tag),
      .o_match      (w_match[g]),
      .o_data       (w_way_data[g]),
      .i_wr_en      ((r_state == REFILL) && i_mem_ack && (r_victim == c_WAYB'(g))),
      .i_wr_index   (w_ref_index),
      .i_wr_word    (r_cnt),
      .i_wr_data    (i_mem_data),
      .i_commit     ((r_state == COMMIT) && (r_victim == c_WAYB'(g))),
      .i_commit_tag (w_ref_tag),
      .i_flush      (r_state == FLUSH)
    );
  end

  always_comb begin
    w_rd_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_match[w]) begin
        w_rd_data = w_rd_data | w_way_data[w];
      end
    end
  end

  assign o_hit      = (r_state == IDLE) && i_rd && (|w_match);
  assign o_data     = o_hit ? w_rd_data : '0;
  assign o_busy     = (r_state != IDLE);
  assign o_mem_rd   = (r_state == REFILL);
  assign o_mem_addr = (r_state == REFILL) ? (r_base + ADDR_WIDTH'({r_cnt, 2'b00})) : '0;
  assign w_last_ack = (r_state == REFILL) && i_mem_ack && (r_cnt == c_WB'(BLOCKS - 1));

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE: begin
        if (i_flush || r_flush_pend) begin
          w_state_nx = FLUSH;
        end else if (i_rd && !(|w_match)) begin
          w_state_nx = REFILL;
        end
      end
      REFILL: if (w_last_ack) w_state_nx = COMMIT;
      COMMIT: w_state_nx = (r_flush_pend || i_flush) ? FLUSH : IDLE;
      FLUSH:  w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  assign w_start_refill = (r_state == IDLE) && (w_state_nx == REFILL);
  assign w_enter_flush  = (r_state != FLUSH) && (w_state_nx == FLUSH);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= IDLE;
      r_base       <= '0;
      r_cnt        <= '0;
      r_victim     <= '0;
      r_flush_pend <= 1'b0;
      r_rr         <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_start_refill) begin
        r_base   <= i_addr & ~c_LINE_MASK;
        r_cnt    <= '0;
        r_victim <= r_rr[w_index];
      end else if ((r_state == REFILL) && i_mem_ack) begin
        r_cnt <= r_cnt + c_WB'(1);
      end
      if (w_enter_flush) begin
        r_flush_pend <= 1'b0;
      end else if (i_flush && (r_state == REFILL)) begin
        r_flush_pend <= 1'b1;
      end
      // A single way has nothing to rotate; its pointer must stay at zero.
      if (r_state == FLUSH) begin
        r_rr <= '0;
      end else if ((r_state == COMMIT) && (WAYS > 1)) begin
        r_rr[w_ref_index] <= r_rr[w_ref_index] + c_WAYB'(1);
      end
    end
  end

`ifdef RV_ICACHE_STATS_EN
  logic [31:0] r_hit_count, r_miss_count;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (o_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_start_refill && (r_miss_count != 32'hFFFF_FFFF)) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;
`endif

  a_one_match: assert property (@(posedge i_clock) disable iff (!i_reset) $onehot0(w_match));

endmodule

`default_nettype wire

// File: tb/tb_icache_nway.sv
// +--------------------------------------------------------------------------+
// | tb_icache_nway : directed scoreboard bench for icache_nway               |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_icache_nway;

  logic        i_clock = 1'b0;
  logic        i_reset, i_rd, i_flush, i_mem_ack;
  logic [31:0] i_addr, i_mem_data;
  logic [31:0] o_data, o_mem_addr;
  logic        o_hit, o_busy, o_mem_rd;
`ifdef RV_ICACHE_STATS_EN
  logic [31:0] o_hit_count, o_miss_count;
`endif

  int total = 0;
  int bad   = 0;
  int g_lat = 0;
  int wait_cnt;
  logic [31:0] exp_addr [$];
  logic [31:0] exp_data [$];

  icache_nway dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_addr     (i_addr),
    .i_rd       (i_rd),
    .o_data     (o_data),
    .o_hit      (o_hit),
    .o_busy     (o_busy),
    .i_flush    (i_flush),
    .o_mem_addr (o_mem_addr),
    .o_mem_rd   (o_mem_rd),
    .i_mem_data (i_mem_data),
    .i_mem_ack  (i_mem_ack)
`ifdef RV_ICACHE_STATS_EN
    ,
    .o_hit_count  (o_hit_count),
    .o_miss_count (o_miss_count)
`endif
  );

  always #5 i_clock = ~i_clock;

  // Distinct word per address; the 0x100 line returns 0xA0..0xA3.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + {30'd0, a[3:2]} + (((a >> 4) - 32'h10) << 8);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder: each request acked after g_lat idle cycles.
  initial begin
    i_mem_ack  = 1'b0;
    i_mem_data = '0;
    wait_cnt   = 0;
    forever begin
      @(negedge i_clock);
      i_mem_ack = 1'b0;
      if (i_reset && o_mem_rd) begin
        if (wait_cnt >= g_lat) begin
          wait_cnt = 0;
          check("mem_req_expected", 32'(exp_addr.size() != 0), 32'd1);
          if (exp_addr.size() != 0) check("mem_addr", o_mem_addr, exp_addr.pop_front());
          i_mem_data = mem_word(o_mem_addr);
          i_mem_ack  = 1'b1;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic push_line(input logic [31:0] a);
    for (int w = 0; w < 4; w++) exp_addr.push_back((a & ~32'hF) + 32'(4 * w));
  endtask

  task automatic fetch(input logic [31:0] a, input bit miss, input string tag);
    int cyc;
    @(negedge i_clock);
    i_addr = a;
    i_rd   = 1'b1;
    exp_data.push_back(mem_word(a));
    #1;
    if (miss) begin
      check({tag, "_miss"}, 32'(o_hit), 32'd0);
      push_line(a);
      cyc = 0;
      while (!o_hit && cyc < 200) begin
        @(negedge i_clock);
        #1;
        cyc++;
      end
      check({tag, "_cycles"}, 32'(cyc), 32'(4 * (g_lat + 1) + 2));
      check({tag, "_refill_done"}, 32'(exp_addr.size()), 32'd0);
    end
    check({tag, "_hit"}, 32'(o_hit), 32'd1);
    check({tag, "_data"}, o_data, exp_data.pop_front());
    check({tag, "_no_mem_rd"}, 32'(o_mem_rd), 32'd0);
    @(negedge i_clock);
    i_rd = 1'b0;
  endtask

  task automatic flush_pulse(input string tag);
    @(negedge i_clock);
    i_flush = 1'b1;
    @(negedge i_clock);
    i_flush = 1'b0;
    #1;
    check({tag, "_busy"}, 32'(o_busy), 32'd1);
    @(negedge i_clock);
    #1;
    check({tag, "_done"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    i_reset = 1'b0;
    i_rd    = 1'b1;
    i_addr  = 32'h100;
    i_flush = 1'b0;
    #12;
    check("rst_hit",      32'(o_hit),    32'd0);
    check("rst_busy",     32'(o_busy),   32'd0);
    check("rst_mem_rd",   32'(o_mem_rd), 32'd0);
    check("rst_mem_addr", o_mem_addr,    32'd0);
    check("rst_data",     o_data,        32'd0);
    @(negedge i_clock);
    i_reset = 1'b1;
    i_rd    = 1'b0;

    // cold miss then a hit on another word of the same line
    g_lat = 0;
    fetch(32'h100, 1'b1, "cold");
    fetch(32'h108, 1'b0, "cold_w2");

    // three lines on set 0 with two ways: round-robin evicts 0x000
    g_lat = 1;
    fetch(32'h000, 1'b1, "c0");
    fetch(32'h400, 1'b1, "c1");
    fetch(32'h800, 1'b1, "c2");
    fetch(32'h400, 1'b0, "c1_keep");
    fetch(32'h000, 1'b1, "c0_evicted");

    g_lat = 0;
    fetch(32'h100, 1'b0, "pre_flush");
    flush_pulse("flush");
    fetch(32'h100, 1'b1, "post_flush");

    // flush during refill: refill finishes, COMMIT, FLUSH, retry misses again
    flush_pulse("flush2");
    g_lat = 2;
    @(negedge i_clock);
    i_addr = 32'h100;
    i_rd   = 1'b1;
    push_line(32'h100);
    #1;
    cyc = 0;
    while (exp_addr.size() != 3 && cyc < 50) begin
      @(negedge i_clock);
      #1;
      cyc++;
    end
    check("fdr_first_ack", 32'(exp_addr.size()), 32'd3);
    @(negedge i_clock);
    i_flush = 1'b1;
    cyc++;
    @(negedge i_clock);
    i_flush = 1'b0;
    cyc++;
    #1;
    while (o_busy && cyc < 100) begin
      @(negedge i_clock);
      #1;
      cyc++;
    end
    check("fdr_busy_cycles", 32'(cyc), 32'(4 * (g_lat + 1) + 3));
    check("fdr_refill_done", 32'(exp_addr.size()), 32'd0);
    check("fdr_miss_again",  32'(o_hit), 32'd0);
    push_line(32'h100);
    exp_data.push_back(mem_word(32'h100));
    cyc = 0;
    while (!o_hit && cyc < 100) begin
      @(negedge i_clock);
      #1;
      cyc++;
    end
    check("fdr_retry_cycles", 32'(cyc), 32'(4 * (g_lat + 1) + 2));
    check("fdr_retry_data", o_data, exp_data.pop_front());
    @(negedge i_clock);
    i_rd = 1'b0;

    // asynchronous reset after two acks of a refill
    g_lat = 1;
    @(negedge i_clock);
    i_addr = 32'h300;
    i_rd   = 1'b1;
    push_line(32'h300);
    cyc = 0;
    while (exp_addr.size() != 2 && cyc < 50) begin
      @(negedge i_clock);
      #1;
      cyc++;
    end
    check("arst_two_acks", 32'(exp_addr.size()), 32'd2);
    @(negedge i_clock);
    #1;
    check("arst_pre_mem_rd", 32'(o_mem_rd), 32'd1);
    #1;
    i_reset   = 1'b0;
    i_mem_ack = 1'b0;
    #1;
    check("arst_mem_rd",   32'(o_mem_rd), 32'd0);
    check("arst_busy",     32'(o_busy),   32'd0);
    check("arst_mem_addr", o_mem_addr,    32'd0);
    exp_addr.delete();
    i_rd = 1'b0;
    @(negedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b1;

`ifdef RV_ICACHE_STATS_EN
    #1;
    check("stats_rst_hit",  o_hit_count,  32'd0);
    check("stats_rst_miss", o_miss_count, 32'd0);
`endif
    fetch(32'h100, 1'b1, "post_arst");
    fetch(32'h104, 1'b0, "post_arst_w1");
    fetch(32'h108, 1'b0, "post_arst_w2");
    fetch(32'h10C, 1'b0, "post_arst_w3");
    fetch(32'h100, 1'b0, "post_arst_w0");
`ifdef RV_ICACHE_STATS_EN
    #1;
    check("stats_hit",  o_hit_count,  32'd5);
    check("stats_miss", o_miss_count, 32'd1);
    flush_pulse("stats_flush");
    check("stats_hit_kept",  o_hit_count,  32'd5);
    check("stats_miss_kept", o_miss_count, 32'd1);
`endif
    fetch(32'h300, 1'b1, "post_arst_b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/icache_nway.md
Name: icache_nway

Overview:
- Parametrised N-way set-associative instruction cache between the fetch stage and the instruction memory port.
- Successor to the single-way icache: generalises ways, element count and block size. Adds per-set round-robin replacement, whole-cache flush, and a sequential refill handshake toward memory.
- Read-only: there is no write path from the CPU side.

Parameters:
- DATA_WIDTH, 32, instruction word width in bits.
- ADDR_WIDTH, 32, byte address width in bits.
- WAYS, 2, number of ways; power of two, 1..8.
- ELEMENTS, 64, number of sets; power of two, >=2.
- BLOCKS, 4, words per line; power of two, >=2.

Ports:
- i_clock  in  1  system clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_addr  in  ADDR_WIDTH  fetch byte address; word aligned.
- i_rd  in  1  fetch request.
- o_data  out  DATA_WIDTH  instruction; valid when o_hit=1.
- o_hit  out  1  i_rd hit this cycle (combinational).
- o_busy  out  1  refill or flush in progress.
- i_flush  in  1  invalidate all lines (one-cycle pulse).
- o_mem_addr  out  ADDR_WIDTH  refill word address.
- o_mem_rd  out  1  refill read request.
- i_mem_data  in  DATA_WIDTH  refill word.
- i_mem_ack  in  1  i_mem_data valid; consumes the current request.

Behaviour:
- Address split, LSB first:
  - 2 byte bits, ignored.
  - log2(BLOCKS) word bits.
  - log2(ELEMENTS) index bits.
  - remaining upper bits are the tag.
- Reset (i_reset=0, asynchronous):
  - all valid bits cleared; round-robin pointers = 0; FSM = IDLE.
  - o_hit=0, o_busy=0, o_mem_rd=0, o_mem_addr=0, o_data=0.
- Lookup: combinational in IDLE. o_hit = i_rd & some way has valid & tag match. o_data is the matching way's word. At most one way may match; a multiple match is illegal and is flagged by an assertion.
- Hit latency: 0 cycles. A miss costs BLOCKS*(ack latency) + 2 cycles.
- FSM IDLE:
  - i_flush=1 -> FLUSH, taking priority over a simultaneous miss.
  - i_rd=1 and no hit -> REFILL. Latch the line base address (word bits = 0). The victim way is rr_ptr[index]. Word counter = 0.
- FSM REFILL:
  - o_busy=1; o_mem_rd=1; o_mem_addr = base + counter*4.
  - On each i_mem_ack, write i_mem_data to victim[index][counter] and increment the counter.
  - On the ack with counter = BLOCKS-1 -> COMMIT.
  - o_mem_rd stays asserted with a stable address until ack; at most one outstanding request.
- FSM COMMIT (1 cycle):
  - o_busy=1; set tag and valid for the victim; increment rr_ptr[index] modulo WAYS.
  - If a flush was latched during refill -> FLUSH, otherwise -> IDLE. The retried fetch then hits.
- FSM FLUSH (1 cycle): o_busy=1; clear every valid bit and every rr_ptr -> IDLE.
- o_hit is forced to 0 whenever the FSM is not IDLE.
- i_flush outside IDLE is latched into a pending bit, which is consumed on entry to FLUSH.
- Reset mid-refill: the partial line is never marked valid and memory requests stop immediately. The memory side must drop any in-flight ack.
- i_rd changing during REFILL is ignored. The CPU must hold the address until o_hit.
- Wrap: the word counter and rr_ptr wrap modulo their power-of-two ranges.
- Tag/valid/rr arrays are flops. The data array may be flops or an async-read RAM.

Optional Feature:
- RV_ICACHE_STATS_EN defined:
  - adds outputs o_hit_count and o_miss_count, 32 bits each, reset to 0, saturating at 0xFFFFFFFF.
  - hit increments on any cycle with o_hit=1.
  - miss increments on each IDLE->REFILL transition.
  - flush does not clear the counters.
- Not defined: the ports and counters are absent, with no logic or area cost.

Decomposition:
- Shared package (the core Config package) holds:
  - RV_ICACHE_WAYS, RV_ICACHE_ELEMENTS, RV_ICACHE_BLOCKS defaults.
  - derived widths: WORD_BITS, INDEX_BITS, TAG_BITS.
  - typedef icache_state_t (IDLE, REFILL, COMMIT, FLUSH).
  - typedefs tag_t and index_t.
- One sub-module: icache_way, a single way's tag/valid/data storage with a compare output and a line write port. It is instantiated WAYS times by a generate loop.

Test Plan:
- Cold miss: reset, i_rd at 0x100 with WAYS=2, BLOCKS=4 -> o_busy; mem reads 0x100, 0x104, 0x108, 0x10C; acks return 0xA0..0xA3. The next cycle at 0x108 gives o_hit=1, o_data=0xA2, with no mem request.
- Conflict: ELEMENTS=64, line size 16 B, fill 0x000, 0x400, 0x800, all index 0. Then 0x000 misses because way0 was evicted by round-robin, while 0x400 still hits.
- Flush: after filling 0x100, pulse i_flush -> o_busy for 1 cycle; the next 0x100 read misses.
- Flush during refill: pulse i_flush while the 2nd word is outstanding -> the refill completes, COMMIT, then FLUSH. The re-request of 0x100 misses again.
- Async reset mid-refill: drop i_reset after 2 acks -> o_mem_rd=0 immediately; after release, 0x100 misses and a full refill follows.
- Stats (RV_ICACHE_STATS_EN): 1 miss then 5 hits -> o_miss_count=1, o_hit_count=5; unchanged after a flush.
